// File: rtl/mt_pkg.sv
// Shared definitions for the multithreaded fetch path.
//   NT_DEFAULT  : default number of hardware threads
//   INSTR_BYTES : fetch advance per instruction
//   thread_state_t : per-thread run state
//   tid_width() : thread-id width for a given thread count (at least 1 bit)
package mt_pkg;

  localparam int NT_DEFAULT  = 4;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {T_IDLE, T_RUN, T_WAIT} thread_state_t;

  function automatic int tid_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter, purely combinational.
// Grants the first requester strictly after 'last', wrapping modulo NT.
//   req       : request vector, bit i = requester i
//   last      : id granted most recently
//   gnt_valid : at least one request present
//   gnt_id    : granted id (0 when gnt_valid=0)
module rr_arbiter
  import mt_pkg::*;
#(
  parameter  int NT   = NT_DEFAULT,
  localparam int TIDW = tid_width(NT)
) (
  input  logic [NT-1:0]   req,
  input  logic [TIDW-1:0] last,
  output logic            gnt_valid,
  output logic [TIDW-1:0] gnt_id
);

  logic [TIDW-1:0] idx;

  // Scan offsets 1..NT from 'last'; NT is a power of two so the add wraps
  // naturally and offset NT lands back on 'last' itself.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    for (int i = 1; i <= NT; i++) begin
      idx = last + TIDW'(i);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = idx;
      end
    end
  end

endmodule

// File: rtl/thread_fetch_scheduler.sv
// Fine-grained multithreading fetch sequencer.
// Keeps a PC and run state per hardware thread, picks one RUN thread per
// cycle round-robin and presents its PC to instruction fetch.
//   clk, nReset      : clock, asynchronous active-low reset
//   stall            : fetch cannot accept; hold selection and PCs
//   start_*          : start an IDLE thread at start_pc
//   redirect_*       : resolved taken branch/jump for a thread
//   halt_*           : thread returns to IDLE
//   wait_* / wake_*  : thread blocks / resumes
//   fetch_valid/tid/pc : selected thread and its PC (same cycle)
//   run_mask         : bit i = thread i in RUN
//   all_idle         : every thread IDLE
module thread_fetch_scheduler
  import mt_pkg::*;
#(
  parameter  int              NT       = NT_DEFAULT,
  parameter  int              XLEN     = 32,
  parameter  logic [XLEN-1:0] RESET_PC = '0,
  localparam int              TIDW     = tid_width(NT)
) (
  input  logic            clk,
  input  logic            nReset,
  input  logic            stall,
  input  logic            start_valid,
  input  logic [TIDW-1:0] start_tid,
  input  logic [XLEN-1:0] start_pc,
  input  logic            redirect_valid,
  input  logic [TIDW-1:0] redirect_tid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt_valid,
  input  logic [TIDW-1:0] halt_tid,
  input  logic            wait_valid,
  input  logic [TIDW-1:0] wait_tid,
  input  logic            wake_valid,
  input  logic [TIDW-1:0] wake_tid,
  output logic            fetch_valid,
  output logic [TIDW-1:0] fetch_tid,
  output logic [XLEN-1:0] fetch_pc,
  output logic [NT-1:0]   run_mask,
  output logic            all_idle
);

  thread_state_t   state_q [NT];
  thread_state_t   state_d [NT];
  logic [XLEN-1:0] pc_q    [NT];
  logic [XLEN-1:0] pc_d    [NT];
  logic [TIDW-1:0] last_q;
  logic [TIDW-1:0] last_d;

  logic            gnt_valid;
  logic [TIDW-1:0] gnt_id;
  logic            advance;

  always_comb begin
    run_mask = '0;
    all_idle = 1'b1;
    for (int t = 0; t < NT; t++) begin
      run_mask[t] = (state_q[t] == T_RUN);
      if (state_q[t] != T_IDLE) all_idle = 1'b0;
    end
  end

  rr_arbiter #(.NT(NT)) u_arb (
    .req       (run_mask),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign fetch_valid = gnt_valid;
  assign fetch_tid   = gnt_valid ? gnt_id : '0;
  assign fetch_pc    = gnt_valid ? pc_q[gnt_id] : RESET_PC;
  assign advance     = gnt_valid && !stall;

  // Updates are applied lowest priority first so that later assignments win:
  // increment < start < redirect < wait < halt.
  always_comb begin
    last_d = advance ? gnt_id : last_q;
    for (int t = 0; t < NT; t++) begin
      state_d[t] = state_q[t];
      pc_d[t]    = pc_q[t];

      if (advance && gnt_id == TIDW'(t))
        pc_d[t] = pc_q[t] + XLEN'(INSTR_BYTES);

      if (start_valid && start_tid == TIDW'(t) && state_q[t] == T_IDLE) begin
        state_d[t] = T_RUN;
        pc_d[t]    = start_pc;
      end

      // Redirect also applies to IDLE threads; it only moves the PC.
      if (redirect_valid && redirect_tid == TIDW'(t))
        pc_d[t] = redirect_pc;

      if (wake_valid && wake_tid == TIDW'(t) && state_q[t] == T_WAIT)
        state_d[t] = T_RUN;

      if (wait_valid && wait_tid == TIDW'(t) && state_q[t] == T_RUN)
        state_d[t] = T_WAIT;

      // Halt drops any same-cycle PC change and parks the thread.
      if (halt_valid && halt_tid == TIDW'(t) && state_q[t] != T_IDLE) begin
        state_d[t] = T_IDLE;
        pc_d[t]    = pc_q[t];
      end
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      last_q <= TIDW'(NT - 1);
      for (int t = 0; t < NT; t++) begin
        state_q[t] <= T_IDLE;
        pc_q[t]    <= RESET_PC;
      end
    end else begin
      last_q <= last_d;
      for (int t = 0; t < NT; t++) begin
        state_q[t] <= state_d[t];
        pc_q[t]    <= pc_d[t];
      end
    end
  end

endmodule

// File: tb/tb_thread_fetch_scheduler.sv
module tb_thread_fetch_scheduler;

  localparam int NT   = 4;
  localparam int XLEN = 32;
  localparam int TIDW = 2;

  logic            clk = 1'b0;
  logic            nReset;
  logic            stall;
  logic            start_valid;
  logic [TIDW-1:0] start_tid;
  logic [XLEN-1:0] start_pc;
  logic            redirect_valid;
  logic [TIDW-1:0] redirect_tid;
  logic [XLEN-1:0] redirect_pc;
  logic            halt_valid;
  logic [TIDW-1:0] halt_tid;
  logic            wait_valid;
  logic [TIDW-1:0] wait_tid;
  logic            wake_valid;
  logic [TIDW-1:0] wake_tid;
  logic            fetch_valid;
  logic [TIDW-1:0] fetch_tid;
  logic [XLEN-1:0] fetch_pc;
  logic [NT-1:0]   run_mask;
  logic            all_idle;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  thread_fetch_scheduler #(.NT(NT), .XLEN(XLEN), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .nReset         (nReset),
    .stall          (stall),
    .start_valid    (start_valid),
    .start_tid      (start_tid),
    .start_pc       (start_pc),
    .redirect_valid (redirect_valid),
    .redirect_tid   (redirect_tid),
    .redirect_pc    (redirect_pc),
    .halt_valid     (halt_valid),
    .halt_tid       (halt_tid),
    .wait_valid     (wait_valid),
    .wait_tid       (wait_tid),
    .wake_valid     (wake_valid),
    .wake_tid       (wake_tid),
    .fetch_valid    (fetch_valid),
    .fetch_tid      (fetch_tid),
    .fetch_pc       (fetch_pc),
    .run_mask       (run_mask),
    .all_idle       (all_idle)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_fetch(input string tag, input logic v, input logic [TIDW-1:0] tid,
                           input logic [XLEN-1:0] pc);
    chk({tag, ".valid"}, 64'(fetch_valid), 64'(v));
    chk({tag, ".tid"},   64'(fetch_tid),   64'(tid));
    chk({tag, ".pc"},    64'(fetch_pc),    64'(pc));
  endtask

  task automatic clr_ev();
    start_valid    = 1'b0; start_tid    = '0; start_pc    = '0;
    redirect_valid = 1'b0; redirect_tid = '0; redirect_pc = '0;
    halt_valid     = 1'b0; halt_tid     = '0;
    wait_valid     = 1'b0; wait_tid     = '0;
    wake_valid     = 1'b0; wake_tid     = '0;
  endtask

  // Advance one clock, then sample 1 ns after the edge and drop one-shot events.
  task automatic tick();
    @(posedge clk);
    #1;
    clr_ev();
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    repeat (2) @(posedge clk);
    #3 nReset = 1'b1;
    tick();
  endtask

  initial begin
    stall = 1'b0;
    clr_ev();
    do_reset();

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      chk("idle.valid", 64'(fetch_valid), 64'd0);
      chk("idle.all_idle", 64'(all_idle), 64'd1);
      chk("idle.pc", 64'(fetch_pc), 64'd0);
      tick();
    end
    chk("idle.run_mask", 64'(run_mask), 64'd0);

    // Single thread start and sequential fetch
    start_valid = 1'b1; start_tid = 2'd0; start_pc = 32'h100;
    tick();
    chk("t0.run_mask", 64'(run_mask), 64'b0001);
    chk("t0.all_idle", 64'(all_idle), 64'd0);
    chk_fetch("t0.f0", 1'b1, 2'd0, 32'h100);
    tick();
    chk_fetch("t0.f1", 1'b1, 2'd0, 32'h104);
    tick();
    chk_fetch("t0.f2", 1'b1, 2'd0, 32'h108);
    halt_valid = 1'b1; halt_tid = 2'd0;
    tick();
    chk("t0.halt.all_idle", 64'(all_idle), 64'd1);
    chk_fetch("t0.halt", 1'b0, 2'd0, 32'h0);

    // Two threads: start under stall so both begin with pointer at NT-1
    do_reset();
    stall = 1'b1;
    start_valid = 1'b1; start_tid = 2'd0; start_pc = 32'h100;
    tick();
    chk_fetch("two.stall_t0", 1'b1, 2'd0, 32'h100);
    start_valid = 1'b1; start_tid = 2'd2; start_pc = 32'h200;
    tick();
    stall = 1'b0;
    chk("two.run_mask", 64'(run_mask), 64'b0101);
    chk_fetch("two.f0", 1'b1, 2'd0, 32'h100);
    tick();
    chk_fetch("two.f1", 1'b1, 2'd2, 32'h200);
    stall = 1'b1;
    tick();
    chk_fetch("two.stall1", 1'b1, 2'd2, 32'h200);
    tick();
    chk_fetch("two.stall2", 1'b1, 2'd2, 32'h200);
    stall = 1'b0;
    tick();
    chk_fetch("two.f2", 1'b1, 2'd0, 32'h104);
    tick();
    chk_fetch("two.f3", 1'b1, 2'd2, 32'h204);

    // Redirect the thread being advanced
    redirect_valid = 1'b1; redirect_tid = 2'd2; redirect_pc = 32'h300;
    tick();
    chk_fetch("redir.t0", 1'b1, 2'd0, 32'h108);
    tick();
    chk_fetch("redir.t2", 1'b1, 2'd2, 32'h300);

    // Wait t0 while t2 is selected; t0 PC is 0x10C
    wait_valid = 1'b1; wait_tid = 2'd0;
    tick();
    chk("wait.run_mask", 64'(run_mask), 64'b0100);
    chk_fetch("wait.f0", 1'b1, 2'd2, 32'h304);
    tick();
    chk_fetch("wait.f1", 1'b1, 2'd2, 32'h308);
    wake_valid = 1'b1; wake_tid = 2'd0;
    tick();
    chk("wake.run_mask", 64'(run_mask), 64'b0101);
    chk_fetch("wake.t0", 1'b1, 2'd0, 32'h10C);
    halt_valid = 1'b1; halt_tid = 2'd0;
    tick();
    chk_fetch("halt0", 1'b1, 2'd2, 32'h30C);
    halt_valid = 1'b1; halt_tid = 2'd2;
    tick();
    chk("halt.all_idle", 64'(all_idle), 64'd1);
    chk_fetch("halt.none", 1'b0, 2'd0, 32'h0);

    // PC wrap, ignored start, async reset
    start_valid = 1'b1; start_tid = 2'd1; start_pc = 32'hFFFF_FFFC;
    tick();
    chk_fetch("wrap.f0", 1'b1, 2'd1, 32'hFFFF_FFFC);
    tick();
    chk_fetch("wrap.f1", 1'b1, 2'd1, 32'h0);
    start_valid = 1'b1; start_tid = 2'd1; start_pc = 32'h500;
    tick();
    chk_fetch("restart_ignored", 1'b1, 2'd1, 32'h4);
    start_valid = 1'b1; start_tid = 2'd3; start_pc = 32'h700;
    #3 nReset = 1'b0;
    #1;
    chk_fetch("arst", 1'b0, 2'd0, 32'h0);
    chk("arst.run_mask", 64'(run_mask), 64'd0);
    chk("arst.all_idle", 64'(all_idle), 64'd1);
    @(posedge clk);
    #1;
    chk("arst.hold", 64'(all_idle), 64'd1);
    clr_ev();
    #2 nReset = 1'b1;
    tick();
    chk_fetch("post_rst", 1'b0, 2'd0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
